// File: rtl/tt_sweep_pkg.sv
// Shared state encoding and default MISR constants for the truth-table sweeper.
package tt_sweep_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } sweep_state_t;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;
    localparam logic [15:0] DEFAULT_SEED = 16'h0000;

endpackage

// File: rtl/tt_sweep_checker_misr_reg.sv
// Multiple-input signature register: shift left, fold POLY on carry-out, XOR in the sampled word.
module misr_reg
    import tt_sweep_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter int               DIN_W = 2,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEFAULT_SEED)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    input  logic [DIN_W-1:0] din,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_din_ext;
    logic [SIG_W-1:0] w_fold;
    logic [SIG_W-1:0] w_sig_next;

    // Zero-extend the sampled word to the register width, bit by bit.
    genvar gi;
    generate
        for (gi = 0; gi < SIG_W; gi = gi + 1) begin : g_ext
            if (gi < DIN_W) begin : g_bit
                assign w_din_ext[gi] = din[gi];
            end else begin : g_zero
                assign w_din_ext[gi] = 1'b0;
            end
        end
    endgenerate

    assign w_fold     = r_sig[SIG_W-1] ? POLY : '0;
    assign w_sig_next = {r_sig[SIG_W-2:0], 1'b0} ^ w_fold ^ w_din_ext;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sig <= SEED;
        end else if (clear) begin
            r_sig <= SEED;
        end else if (en) begin
            r_sig <= w_sig_next;
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/tt_sweep_checker.sv
// Exhaustive truth-table sweeper: walks every input vector, holds it HOLD cycles,
// compares DUT against reference on the last cycle of each window and signs the DUT stream.
module tt_sweep_checker
    import tt_sweep_pkg::*;
#(
    parameter int               N_IN  = 4,
    parameter int               N_OUT = 2,
    parameter int               HOLD  = 5,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEFAULT_SEED)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic [N_IN-1:0]   vec_out,
    input  logic [N_OUT-1:0]  dut_out,
    input  logic [N_OUT-1:0]  ref_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_cnt,
    output logic              first_fail_valid,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic [SIG_W-1:0]  signature
);

    localparam int                CNT_W    = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(HOLD - 1);
    localparam logic [N_IN-1:0]   VEC_LAST = '1;

    sweep_state_t       r_state;
    logic [N_IN-1:0]    r_vec;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_busy;
    logic               r_done;
    logic               r_pass;
    logic [N_IN:0]      r_err;
    logic               r_ffv;
    logic [N_IN-1:0]    r_ffvec;

    logic               w_launch;
    logic               w_sample;
    logic               w_mismatch;
    logic [N_IN:0]      w_err_next;
    logic [N_OUT-1:0]   w_diff;

    // A sweep may only be launched from a resting state; start during SWEEP is ignored.
    assign w_launch   = start && (r_state == ST_IDLE || r_state == ST_DONE);
    assign w_sample   = (r_state == ST_SWEEP) && (r_cnt == CNT_LAST);
    assign w_diff     = dut_out ^ ref_out;
    assign w_mismatch = |w_diff;
    assign w_err_next = r_err + (N_IN+1)'(w_mismatch);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_vec   <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
            r_ffv   <= 1'b0;
            r_ffvec <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state <= ST_SWEEP;
                        r_vec   <= '0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                        r_err   <= '0;
                        r_ffv   <= 1'b0;
                        r_ffvec <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (r_cnt != CNT_LAST) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end else begin
                        r_err <= w_err_next;
                        if (w_mismatch && !r_ffv) begin
                            r_ffv   <= 1'b1;
                            r_ffvec <= r_vec;
                        end
                        // The all-ones vector ends the sweep, so vec_out never wraps.
                        if (r_vec == VEC_LAST) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_pass  <= (w_err_next == '0);
                        end else begin
                            r_vec <= r_vec + N_IN'(1);
                            r_cnt <= '0;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_pass  <= 1'b0;
                end
            endcase
        end
    end

    misr_reg #(
        .SIG_W (SIG_W),
        .DIN_W (N_OUT),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .clk   (clk),
        .rst   (rst),
        .clear (w_launch),
        .en    (w_sample),
        .din   (dut_out),
        .sig   (signature)
    );

    assign vec_out          = r_vec;
    assign busy             = r_busy;
    assign done             = r_done;
    assign pass             = r_pass;
    assign err_cnt          = r_err;
    assign first_fail_valid = r_ffv;
    assign first_fail_vec   = r_ffvec;

endmodule

// File: tb/tb_tt_sweep_checker.sv
// Directed bench for tt_sweep_checker: N_IN=4/HOLD=5 main instance plus an N_IN=2/HOLD=1 instance.
module tb_tt_sweep_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  vec_out;
    logic [1:0]  dut_out;
    logic [1:0]  ref_out;
    logic        busy, done, pass, ffv;
    logic [4:0]  err_cnt;
    logic [3:0]  ffvec;
    logic [15:0] signature;

    logic        start2;
    logic [1:0]  vec2;
    logic        busy2, done2, pass2, ffv2;
    logic [2:0]  err2;
    logic [1:0]  ffvec2;
    logic [15:0] sig2;

    int n_vec  = 0;
    int n_miss = 0;
    int mode   = 0;

    always #5 clk = ~clk;

    // Golden circuit: a=v[0], b=v[1], c=v[2], d=v[3]; f=a&b|c, g=a^d; out={g,f}.
    function automatic logic [1:0] golden(input logic [3:0] v);
        logic f, g;
        f = (v[0] & v[1]) | v[2];
        g = v[0] ^ v[3];
        return {g, f};
    endfunction

    // 0: correct, 1: inverted at 10 and 13, 2: tied to zero, 3: bit0 flipped at 5.
    function automatic logic [1:0] dut_resp(input logic [3:0] v, input int m);
        logic [1:0] r;
        r = golden(v);
        if (m == 1 && (v == 4'd10 || v == 4'd13)) r = ~r;
        if (m == 2) r = 2'b00;
        if (m == 3 && v == 4'd5) r = r ^ 2'b01;
        return r;
    endfunction

    function automatic logic [15:0] misr_model(input int m);
        logic [15:0] s;
        logic [3:0]  vv;
        s = 16'h0000;
        for (int v = 0; v < 16; v++) begin
            vv = 4'(v);
            s = {s[14:0], 1'b0} ^ (s[15] ? 16'h1021 : 16'h0000) ^ {14'd0, dut_resp(vv, m)};
        end
        return s;
    endfunction

    always_comb begin
        ref_out = golden(vec_out);
        dut_out = dut_resp(vec_out, mode);
    end

    tt_sweep_checker #(.N_IN(4), .N_OUT(2), .HOLD(5), .SIG_W(16),
                       .POLY(16'h1021), .SEED(16'h0000)) u_dut (
        .clk(clk), .rst(rst), .start(start), .vec_out(vec_out),
        .dut_out(dut_out), .ref_out(ref_out), .busy(busy), .done(done),
        .pass(pass), .err_cnt(err_cnt), .first_fail_valid(ffv),
        .first_fail_vec(ffvec), .signature(signature)
    );

    tt_sweep_checker #(.N_IN(2), .N_OUT(2), .HOLD(1), .SIG_W(16),
                       .POLY(16'h1021), .SEED(16'h0000)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .vec_out(vec2),
        .dut_out(vec2), .ref_out(vec2), .busy(busy2), .done(done2),
        .pass(pass2), .err_cnt(err2), .first_fail_valid(ffv2),
        .first_fail_vec(ffvec2), .signature(sig2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ne(input string tag, input logic [31:0] obs, input logic [31:0] bad);
        n_vec++;
        assert (obs !== bad) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected anything but %0h", tag, obs, bad);
        end
    endtask

    // Returns #1 after the edge that samples start (busy should be high there).
    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Checks busy/vec_out at k = 0..last_k after the launch edge; optionally pulses start at pulse_k.
    task automatic follow(input int last_k, input int pulse_k);
        for (int k = 0; k <= last_k; k++) begin
            chk($sformatf("busy k=%0d", k), 32'(busy), 32'd1);
            chk($sformatf("vec k=%0d", k), 32'(vec_out), 32'(k / 5));
            if (k == pulse_k) start = 1'b1;
            if (k < last_k) begin
                @(posedge clk); #1 start = 1'b0;
            end
        end
    endtask

    task automatic finish_sweep(input string tag);
        @(posedge clk); #1;
        chk({tag, " done"}, 32'(done), 32'd1);
        chk({tag, " busy_low"}, 32'(busy), 32'd0);
        chk({tag, " vec_last"}, 32'(vec_out), 32'd15);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start2 = 1'b0;
        #1;
        chk("rst vec", 32'(vec_out), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst pass", 32'(pass), 32'd0);
        chk("rst err", 32'(err_cnt), 32'd0);
        chk("rst ffv", 32'(ffv), 32'd0);
        chk("rst ffvec", 32'(ffvec), 32'd0);
        chk("rst sig", 32'(signature), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Matching run: 80 busy cycles, pass.
        mode = 0;
        pulse_start();
        follow(79, -1);
        finish_sweep("A");
        chk("A err", 32'(err_cnt), 32'd0);
        chk("A pass", 32'(pass), 32'd1);
        chk("A ffv", 32'(ffv), 32'd0);
        chk("A sig", 32'(signature), 32'(misr_model(0)));
        chk_ne("A sig_nonzero", 32'(signature), 32'd0);
        repeat (3) @(posedge clk); #1;
        chk("A frozen_done", 32'(done), 32'd1);

        // Same DUT again with start pulsed at vector 3: ignored, same length and signature.
        pulse_start();
        follow(79, 16);
        finish_sweep("B");
        chk("B pass", 32'(pass), 32'd1);
        chk("B sig", 32'(signature), 32'(misr_model(0)));

        // Faults at vectors 10 and 13.
        mode = 1;
        pulse_start();
        follow(79, -1);
        finish_sweep("C");
        chk("C err", 32'(err_cnt), 32'd2);
        chk("C ffv", 32'(ffv), 32'd1);
        chk("C ffvec", 32'(ffvec), 32'd10);
        chk("C pass", 32'(pass), 32'd0);
        chk("C sig", 32'(signature), 32'(misr_model(1)));

        // Restart from DONE after a failing run: everything cleared, then a clean pass.
        mode = 0;
        pulse_start();
        chk("D done_dropped", 32'(done), 32'd0);
        chk("D err_clr", 32'(err_cnt), 32'd0);
        chk("D ffv_clr", 32'(ffv), 32'd0);
        chk("D ffvec_clr", 32'(ffvec), 32'd0);
        chk("D sig_seed", 32'(signature), 32'd0);
        follow(79, -1);
        finish_sweep("D");
        chk("D pass", 32'(pass), 32'd1);
        chk("D err", 32'(err_cnt), 32'd0);

        // DUT tied low: 13 of 16 golden responses are nonzero; signature stays at seed.
        mode = 2;
        pulse_start();
        follow(79, -1);
        finish_sweep("E");
        chk("E sig_zero", 32'(signature), 32'd0);
        chk("E err", 32'(err_cnt), 32'd13);
        chk("E ffvec", 32'(ffvec), 32'd1);

        // Single-bit fault at vector 5 changes the signature.
        mode = 3;
        pulse_start();
        follow(79, -1);
        finish_sweep("F");
        chk("F err", 32'(err_cnt), 32'd1);
        chk("F ffvec", 32'(ffvec), 32'd5);
        chk_ne("F sig_differs", 32'(signature), 32'(misr_model(0)));
        chk("F sig", 32'(signature), 32'(misr_model(3)));

        // Reset in the middle of vector 7's hold window.
        mode = 1;
        pulse_start();
        follow(37, -1);
        rst = 1'b1;
        #1;
        chk("G rst_busy", 32'(busy), 32'd0);
        chk("G rst_vec", 32'(vec_out), 32'd0);
        chk("G rst_err", 32'(err_cnt), 32'd0);
        chk("G rst_ffv", 32'(ffv), 32'd0);
        chk("G rst_sig", 32'(signature), 32'd0);
        chk("G rst_done", 32'(done), 32'd0);
        #1 rst = 1'b0;
        mode = 0;
        pulse_start();
        follow(79, -1);
        finish_sweep("H");
        chk("H pass", 32'(pass), 32'd1);
        chk("H sig", 32'(signature), 32'(misr_model(0)));

        // HOLD=1, N_IN=2: new vector every cycle, done 4 cycles after busy rises.
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("H1 busy k=%0d", k), 32'(busy2), 32'd1);
            chk($sformatf("H1 vec k=%0d", k), 32'(vec2), 32'(k));
            chk($sformatf("H1 done_low k=%0d", k), 32'(done2), 32'd0);
            @(posedge clk); #1;
        end
        chk("H1 done", 32'(done2), 32'd1);
        chk("H1 busy_low", 32'(busy2), 32'd0);
        chk("H1 pass", 32'(pass2), 32'd1);
        chk("H1 err", 32'(err2), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
